// File: rtl/chatter_gen.sv
// Bounce/chatter emulator: each accepted level change of sig_i makes sig_o toggle
// pseudo-randomly for bounce_len cycles, then settle to the new level.
module chatter_gen #(
    parameter int                    P_CNT_BIT   = 32,
    parameter int                    P_LFSR_BIT  = 16,
    parameter logic [P_LFSR_BIT-1:0] P_LFSR_TAPS = 16'hB400,
    parameter logic [P_LFSR_BIT-1:0] P_LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic                 sig_i,
    input  logic [P_CNT_BIT-1:0] bounce_len,
    input  logic [P_CNT_BIT-1:0] toggle_div,
    output logic                 sig_o,
    output logic                 busy,
    output logic                 done
);

    localparam logic [P_LFSR_BIT-1:0] L_SEED =
        (P_LFSR_SEED == '0) ? P_LFSR_BIT'(1) : P_LFSR_SEED;

    typedef enum logic {S_IDLE, S_BOUNCE} state_t;

    state_t                r_state;
    logic                  r_sig_s;
    logic                  r_target;
    logic                  r_sig_o;
    logic                  r_busy;
    logic                  r_done;
    logic [P_CNT_BIT-1:0]  r_bcount;
    logic [P_CNT_BIT-1:0]  r_tcount;
    logic [P_LFSR_BIT-1:0] r_lfsr;

    logic                  w_edge;
    logic [P_CNT_BIT:0]    w_bnext;
    logic [P_CNT_BIT:0]    w_tnext;
    logic [P_CNT_BIT:0]    w_len;
    logic [P_CNT_BIT:0]    w_div;
    logic                  w_settle;
    logic                  w_toggle;
    logic [P_LFSR_BIT-1:0] w_lfsr_next;

    // Compare one bit wider so all-ones bounce_len/toggle_div never wrap the count.
    assign w_edge      = (r_sig_s != r_target);
    assign w_bnext     = {1'b0, r_bcount} + (P_CNT_BIT+1)'(1);
    assign w_tnext     = {1'b0, r_tcount} + (P_CNT_BIT+1)'(1);
    assign w_len       = {1'b0, bounce_len};
    assign w_div       = (toggle_div == '0) ? (P_CNT_BIT+1)'(1) : {1'b0, toggle_div};
    assign w_settle    = (w_bnext >= w_len);
    assign w_toggle    = (w_tnext >= w_div);
    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? P_LFSR_TAPS : '0);

    assign sig_o = r_sig_o;
    assign busy  = r_busy;
    assign done  = r_done;

    // NOTE: all state here is sequential, so every assignment is non-blocking (<=).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_sig_s  <= 1'b0;
            r_target <= 1'b0;
            r_sig_o  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_bcount <= '0;
            r_tcount <= '0;
            r_lfsr   <= L_SEED;
        end else begin
            r_sig_s <= sig_i;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_edge) begin
                        r_target <= r_sig_s;
                        if (!en || bounce_len == '0) begin
                            r_sig_o <= r_sig_s;
                        end else begin
                            r_bcount <= '0;
                            r_tcount <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_BOUNCE;
                        end
                    end
                end
                S_BOUNCE: begin
                    if (!en) begin
                        r_sig_o <= r_target;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_edge) begin
                        r_target <= r_sig_s;
                        r_bcount <= '0;
                        r_tcount <= '0;
                    end else if (w_settle) begin
                        r_sig_o <= r_target;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_bcount <= w_bnext[P_CNT_BIT-1:0];
                        // A toggle opportunity flips sig_o by the freshly shifted LFSR bit.
                        if (w_toggle) begin
                            r_tcount <= '0;
                            r_lfsr   <= w_lfsr_next;
                            r_sig_o  <= r_sig_o ^ w_lfsr_next[0];
                        end else begin
                            r_tcount <= w_tnext[P_CNT_BIT-1:0];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chatter_gen.sv
// Self-checking bench for chatter_gen: per-cycle sig_o/busy/done expectations are
// queued from the timing rules and an LFSR model, then compared as the DUT runs.
module tb_chatter_gen;

    localparam logic [15:0] C_SEED = 16'hACE1;
    localparam logic [15:0] C_TAPS = 16'hB400;

    typedef struct packed {
        logic so;
        logic bsy;
        logic dn;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic        sig_i;
    logic [31:0] bounce_len;
    logic [31:0] toggle_div;
    logic        sig_o;
    logic        busy;
    logic        done;

    exp_t        q[$];
    logic [15:0] lfsr_m;
    logic        exp_so;
    string       cur;
    int          n_pass = 0;
    int          n_chk  = 0;

    logic        flt_out;
    int          flt_ph;
    int          flt_cnt;
    int          flt_trans;

    chatter_gen dut (
        .clk        (clk),
        .resetn     (resetn),
        .en         (en),
        .sig_i      (sig_i),
        .bounce_len (bounce_len),
        .toggle_div (toggle_div),
        .sig_o      (sig_o),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic obs, input logic expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s/%s @%0t: observed %b expected %b", cur, tag, $time, obs, expv);
    endtask

    task automatic lfsr_step();
        logic out;
        out    = lfsr_m[0];
        lfsr_m = lfsr_m >> 1;
        if (out) lfsr_m = lfsr_m ^ C_TAPS;
    endtask

    task automatic push(input logic so, input logic bsy, input logic dn);
        q.push_back('{so, bsy, dn});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push(exp_so, 1'b0, 1'b0);
    endtask

    // Entry cycle, then k = 1..L after entry; stop > 0 ends the window before cycle k = stop.
    task automatic push_window(input int len, input int div, input int stop, input logic tgt);
        int dd;
        dd = (div == 0) ? 1 : div;
        push(exp_so, 1'b1, 1'b0);
        for (int k = 1; k <= len; k++) begin
            if (stop != 0 && k == stop) return;
            if (k == len) begin
                exp_so = tgt;
                push(exp_so, 1'b0, 1'b1);
            end else begin
                if (k % dd == 0) begin
                    lfsr_step();
                    exp_so = exp_so ^ lfsr_m[0];
                end
                push(exp_so, 1'b1, 1'b0);
            end
        end
    endtask

    task automatic consume(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                check("queue_empty", 1'b1, 1'b0);
            end else begin
                e = q.pop_front();
                check("sig_o", sig_o, e.so);
                check("busy", busy, e.bsy);
                check("done", done, e.dn);
            end
            // Debounce filter model: sample every 8 cycles, flip after 4 differing samples.
            flt_ph++;
            if (flt_ph == 8) begin
                flt_ph = 0;
                if (sig_o !== flt_out) begin
                    flt_cnt++;
                    if (flt_cnt == 4) begin
                        flt_out = ~flt_out;
                        flt_cnt = 0;
                        flt_trans++;
                    end
                end else begin
                    flt_cnt = 0;
                end
            end
        end
    endtask

    task automatic drain();
        consume(q.size());
    endtask

    task automatic bypass_edge(input logic lvl);
        sig_i = lvl;
        push_idle(1);
        exp_so = lvl;
        push(exp_so, 1'b0, 1'b0);
        push_idle(2);
        drain();
    endtask

    task automatic edge_window(input logic lvl, input int len, input int div);
        sig_i      = lvl;
        bounce_len = len;
        toggle_div = div;
        push_idle(1);
        push_window(len, div, 0, lvl);
        push_idle(2);
        drain();
    endtask

    task automatic loopback(input logic lvl);
        flt_out    = exp_so;
        flt_cnt    = 0;
        flt_ph     = 0;
        flt_trans  = 0;
        sig_i      = lvl;
        bounce_len = 1000;
        toggle_div = 3;
        push_idle(1);
        push_window(1000, 3, 0, lvl);
        push_idle(64);
        drain();
        check("flt_level", flt_out, lvl);
        check("flt_net_change", flt_trans[0], 1'b1);
    endtask

    initial begin
        resetn     = 1'b0;
        en         = 1'b1;
        sig_i      = 1'b1;
        bounce_len = 20;
        toggle_div = 1;
        lfsr_m     = C_SEED;
        exp_so     = 1'b0;
        flt_out    = 1'b0;
        flt_ph     = 0;
        flt_cnt    = 0;
        flt_trans  = 0;

        cur = "reset";
        repeat (3) @(posedge clk);
        #1;
        check("sig_o", sig_o, 1'b0);
        check("busy", busy, 1'b0);
        check("done", done, 1'b0);
        resetn = 1'b1;
        push_idle(1);
        push_window(20, 1, 0, 1'b1);
        push_idle(2);
        drain();

        cur = "bypass";
        en = 1'b0;
        bypass_edge(1'b0);
        bypass_edge(1'b1);
        bypass_edge(1'b0);
        en = 1'b1;

        cur = "normal";
        edge_window(1'b1, 20, 1);
        cur = "div4";
        edge_window(1'b0, 10, 4);
        cur = "div0";
        edge_window(1'b1, 6, 0);
        cur = "len1";
        edge_window(1'b0, 1, 1);
        cur = "div_ge_len";
        edge_window(1'b1, 5, 8);

        cur = "len0";
        bounce_len = 0;
        bypass_edge(1'b0);

        cur = "retrigger";
        sig_i      = 1'b1;
        bounce_len = 20;
        toggle_div = 1;
        push_idle(1);
        push_window(20, 1, 10, 1'b1);
        push_window(20, 1, 0, 1'b0);
        push_idle(2);
        consume(10);
        sig_i = 1'b0;
        drain();

        cur = "en_drop";
        sig_i = 1'b1;
        push_idle(1);
        push_window(20, 1, 7, 1'b1);
        exp_so = 1'b1;
        push(exp_so, 1'b0, 1'b0);
        push_idle(2);
        consume(8);
        en = 1'b0;
        drain();
        en = 1'b1;
        push_idle(2);
        drain();

        cur = "reset_mid";
        sig_i = 1'b0;
        push_idle(1);
        push_window(20, 1, 0, 1'b0);
        consume(6);
        resetn = 1'b0;
        #1;
        check("sig_o", sig_o, 1'b0);
        check("busy", busy, 1'b0);
        check("done", done, 1'b0);
        q.delete();
        lfsr_m = C_SEED;
        exp_so = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        push_idle(4);
        drain();

        cur = "loopback";
        loopback(1'b1);
        loopback(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
